// File: rtl/cpu_sim_ctrl_if.sv
// cpu_sim_ctrl_if
// Bundles the test-run control and memory-monitor signals of cpu_sim_ctrl.
//   start      : request to begin a test run
//   mem_we     : CPU data-memory write enable (monitored)
//   mem_addr   : CPU data-memory address (monitored)
//   mem_wdata  : CPU data-memory write data (monitored)
//   cpu_rst_n  : active-low reset driven to the CPU under test
//   cycle_cnt  : RUN cycles in the current or last test
//   done       : test finished
//   pass       : test passed (meaningful while done=1)
//   timeout    : test ended because the cycle budget ran out
//   fail_code  : upper DATA_W-1 bits of the terminating tohost write
// master = harness/testbench side, slave = cpu_sim_ctrl side.
interface cpu_sim_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
);
  logic              start;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_rst_n;
  logic [CNT_W-1:0]  cycle_cnt;
  logic              done;
  logic              pass;
  logic              timeout;
  logic [DATA_W-2:0] fail_code;

  modport master (
    output start, mem_we, mem_addr, mem_wdata,
    input  cpu_rst_n, cycle_cnt, done, pass, timeout, fail_code
  );

  modport slave (
    input  start, mem_we, mem_addr, mem_wdata,
    output cpu_rst_n, cycle_cnt, done, pass, timeout, fail_code
  );
endinterface

// File: rtl/cpu_sim_ctrl.sv
// cpu_sim_ctrl
// Simulation harness controller for a CPU under test. Holds the CPU in reset
// for RST_HOLD_CYCLES after a start, releases it, counts RUN cycles and ends
// the test either on a write to TOHOST_ADDR (pass when the data equals 1) or
// after TIMEOUT_CYCLES RUN cycles (0 disables the timeout).
// Ports:
//   clk   : single clock, rising-edge
//   rst_n : asynchronous active-low reset
//   bus   : cpu_sim_ctrl_if.slave (start, memory monitor in; status out)
module cpu_sim_ctrl #(
  parameter int unsigned       ADDR_W          = 32,
  parameter int unsigned       DATA_W          = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR     = 'h0000_1000,
  parameter int unsigned       RST_HOLD_CYCLES = 2,
  parameter int unsigned       TIMEOUT_CYCLES  = 1000,
  parameter int unsigned       CNT_W           = 32,
  parameter bit                AUTO_START      = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  cpu_sim_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RST_HOLD = 2'd1,
    S_RUN      = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_INIT = 8'(RST_HOLD_CYCLES - 1);

  state_t            state_q, state_d;
  logic [7:0]        hold_q, hold_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic [DATA_W-2:0] fail_code_q, fail_code_d;

  logic tohost_hit;
  logic tmo_hit;
  logic enter_hold;

  assign tohost_hit = (state_q == S_RUN) && bus.mem_we && (bus.mem_addr == TOHOST_ADDR);

  // The current RUN cycle is number cycle_cnt_q+1; compared in 64 bits so a
  // narrow CNT_W never aliases a large TIMEOUT_CYCLES.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (state_q == S_RUN) &&
                   ((64'(cycle_cnt_q) + 64'd1) == 64'(TIMEOUT_CYCLES));

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    cycle_cnt_d = cycle_cnt_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    fail_code_d = fail_code_q;
    enter_hold  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start || AUTO_START) enter_hold = 1'b1;
      end
      S_RST_HOLD: begin
        if (hold_q == 8'd0) state_d = S_RUN;
        else                hold_d  = hold_q - 8'd1;
      end
      S_RUN: begin
        if (cycle_cnt_q != {CNT_W{1'b1}}) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        // A tohost hit wins over a simultaneous timeout.
        if (tohost_hit) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          pass_d      = (bus.mem_wdata == DATA_W'(1));
          timeout_d   = 1'b0;
          fail_code_d = bus.mem_wdata[DATA_W-1:1];
        end else if (tmo_hit) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          pass_d      = 1'b0;
          timeout_d   = 1'b1;
          fail_code_d = '0;
        end
      end
      S_DONE: begin
        // AUTO_START deliberately does not apply here: only an explicit start reruns.
        if (bus.start) enter_hold = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_hold) begin
      state_d     = S_RST_HOLD;
      hold_d      = HOLD_INIT;
      cycle_cnt_d = '0;
      done_d      = 1'b0;
      pass_d      = 1'b0;
      timeout_d   = 1'b0;
      fail_code_d = '0;
    end

    // Registered from the next state so the CPU leaves reset on the edge that enters RUN.
    cpu_rst_n_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      hold_q      <= 8'd0;
      cpu_rst_n_q <= 1'b0;
      cycle_cnt_q <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_code_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      cycle_cnt_q <= cycle_cnt_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      fail_code_q <= fail_code_d;
    end
  end

  assign bus.cpu_rst_n = cpu_rst_n_q;
  assign bus.cycle_cnt = cycle_cnt_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.timeout   = timeout_q;
  assign bus.fail_code = fail_code_q;

endmodule

// File: tb/tb_cpu_sim_ctrl.sv
// tb_cpu_sim_ctrl
// Self-checking bench for cpu_sim_ctrl with RST_HOLD_CYCLES=3,
// TIMEOUT_CYCLES=20, AUTO_START=0, TOHOST_ADDR=0x1000.
module tb_cpu_sim_ctrl;

  localparam int          HOLD   = 3;
  localparam int          TO     = 20;
  localparam logic [31:0] TOHOST = 32'h0000_1000;

  logic clk;
  logic rst_n;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_sim_ctrl_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(32)) ifc ();

  cpu_sim_ctrl #(
    .ADDR_W(32), .DATA_W(32), .TOHOST_ADDR(TOHOST), .RST_HOLD_CYCLES(HOLD),
    .TIMEOUT_CYCLES(TO), .CNT_W(32), .AUTO_START(1'b0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          hit_k;     // RUN cycle carrying the tohost write (0 = none)
    logic [31:0] wd;
    bit          decoy;     // write 0x1004 in RUN cycle 2 and tohost in RST_HOLD
    bit          exp_pass;
    bit          exp_to;
    logic [30:0] exp_code;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outcome of one test, from the rules: first tohost write within
  // the budget decides; otherwise the run times out after TO cycles.
  function automatic void model(input int hit_k, input logic [31:0] wd,
                                output bit p, output bit to,
                                output logic [30:0] code, output int cnt);
    if (hit_k >= 1 && hit_k <= TO) begin
      p = (wd == 32'd1); to = 1'b0; code = wd[31:1]; cnt = hit_k;
    end else begin
      p = 1'b0; to = 1'b1; code = '0; cnt = TO;
    end
  endfunction

  task automatic check_status(input string tag, input bit p, input bit to,
                              input logic [30:0] code, input int cnt);
    chk({tag, "_done"},    64'(ifc.done), 64'd1);
    chk({tag, "_pass"},    64'(ifc.pass), 64'(p));
    chk({tag, "_timeout"}, 64'(ifc.timeout), 64'(to));
    chk({tag, "_code"},    64'(ifc.fail_code), 64'(code));
    chk({tag, "_cnt"},     64'(ifc.cycle_cnt), 64'(cnt));
    chk({tag, "_cpurst"},  64'(ifc.cpu_rst_n), 64'd0);
  endtask

  // Called one tick after an edge, with the DUT in IDLE or DONE.
  task automatic run_test(input int hit_k, input logic [31:0] wd, input bit decoy,
                          input bit noise, input bit p, input bit to,
                          input logic [30:0] code, input int cnt);
    int k;
    logic [31:0] a;
    ifc.start = 1'b1;
    step();                                  // E0
    ifc.start = 1'b0;
    chk("clr_done",  64'(ifc.done), 64'd0);
    chk("clr_pass",  64'(ifc.pass), 64'd0);
    chk("clr_to",    64'(ifc.timeout), 64'd0);
    chk("clr_code",  64'(ifc.fail_code), 64'd0);
    chk("clr_cnt",   64'(ifc.cycle_cnt), 64'd0);
    chk("hold_e0",   64'(ifc.cpu_rst_n), 64'd0);
    if (decoy) begin
      ifc.mem_we = 1'b1; ifc.mem_addr = TOHOST; ifc.mem_wdata = 32'd1;
    end
    step();                                  // E1
    chk("hold_e1", 64'(ifc.cpu_rst_n), 64'd0);
    step();                                  // E2
    chk("hold_e2", 64'(ifc.cpu_rst_n), 64'd0);
    ifc.mem_we = 1'b0;
    step();                                  // E3
    chk("run_rise", 64'(ifc.cpu_rst_n), 64'd1);
    chk("run_cnt0", 64'(ifc.cycle_cnt), 64'd0);
    k = 0;
    while (ifc.done !== 1'b1 && k < 40) begin
      k++;
      if (k == hit_k) begin
        ifc.mem_we = 1'b1; ifc.mem_addr = TOHOST; ifc.mem_wdata = wd;
      end else if (decoy && k == 2) begin
        ifc.mem_we = 1'b1; ifc.mem_addr = 32'h0000_1004; ifc.mem_wdata = 32'd1;
      end else if (noise) begin
        ifc.mem_we = 1'($urandom);
        a = $urandom;
        if (a == TOHOST) a = a ^ 32'h4;
        // tohost address without a write enable must also be ignored
        ifc.mem_addr  = ifc.mem_we ? a : TOHOST;
        ifc.mem_wdata = ($urandom_range(0, 1) == 0) ? 32'd1 : $urandom;
      end else begin
        ifc.mem_we = 1'b0;
      end
      step();
      chk("run_cnt", 64'(ifc.cycle_cnt), 64'(k));
      chk("run_cpurst", 64'(ifc.cpu_rst_n), 64'(ifc.done !== 1'b1));
    end
    ifc.mem_we = 1'b0;
    check_status("end", p, to, code, cnt);
    // Writes and idle cycles in DONE must not disturb anything.
    ifc.mem_we = 1'b1; ifc.mem_addr = TOHOST; ifc.mem_wdata = 32'd1;
    step();
    ifc.mem_we = 1'b0;
    step();
    check_status("held", p, to, code, cnt);
  endtask

  initial begin
    bit          p, to;
    logic [30:0] code;
    int          cnt, hk;
    logic [31:0] wd;

    vecs[0] = '{6,  32'h0000_0001, 1'b0, 1'b1, 1'b0, 31'h0,        6};
    vecs[1] = '{4,  32'h0000_0015, 1'b1, 1'b0, 1'b0, 31'hA,        4};
    vecs[2] = '{0,  32'h0000_0001, 1'b0, 1'b0, 1'b1, 31'h0,        20};
    vecs[3] = '{20, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 31'h0,        20};
    vecs[4] = '{21, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 31'h0,        20};
    vecs[5] = '{1,  32'h0000_0000, 1'b0, 1'b0, 1'b0, 31'h0,        1};
    vecs[6] = '{3,  32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 31'h7FFF_FFFF, 3};
    vecs[7] = '{19, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 31'h1,        19};

    rst_n = 1'b0;
    ifc.start = 1'b0; ifc.mem_we = 1'b0; ifc.mem_addr = '0; ifc.mem_wdata = '0;
    #1;
    chk("rst_cpurst", 64'(ifc.cpu_rst_n), 64'd0);
    chk("rst_cnt",    64'(ifc.cycle_cnt), 64'd0);
    chk("rst_done",   64'(ifc.done), 64'd0);
    chk("rst_pass",   64'(ifc.pass), 64'd0);
    chk("rst_to",     64'(ifc.timeout), 64'd0);
    chk("rst_code",   64'(ifc.fail_code), 64'd0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("idle_cpurst", 64'(ifc.cpu_rst_n), 64'd0);
    chk("idle_cnt",    64'(ifc.cycle_cnt), 64'd0);

    for (int i = 0; i < 8; i++)
      run_test(vecs[i].hit_k, vecs[i].wd, vecs[i].decoy, 1'b0,
               vecs[i].exp_pass, vecs[i].exp_to, vecs[i].exp_code, vecs[i].exp_cnt);

    // Asynchronous reset in the middle of RUN.
    ifc.start = 1'b1;
    step();
    ifc.start = 1'b0;
    repeat (HOLD) step();
    repeat (5) step();
    chk("pre_rst_cnt",    64'(ifc.cycle_cnt), 64'd5);
    chk("pre_rst_cpurst", 64'(ifc.cpu_rst_n), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cpurst", 64'(ifc.cpu_rst_n), 64'd0);
    chk("arst_cnt",    64'(ifc.cycle_cnt), 64'd0);
    chk("arst_done",   64'(ifc.done), 64'd0);
    chk("arst_pass",   64'(ifc.pass), 64'd0);
    chk("arst_to",     64'(ifc.timeout), 64'd0);
    #2 rst_n = 1'b1;
    repeat (4) step();
    chk("post_rst_cpurst", 64'(ifc.cpu_rst_n), 64'd0);
    chk("post_rst_cnt",    64'(ifc.cycle_cnt), 64'd0);
    chk("post_rst_done",   64'(ifc.done), 64'd0);

    // Randomized runs against the outcome model.
    for (int i = 0; i < 25; i++) begin
      hk = $urandom_range(1, 24);
      wd = ($urandom_range(0, 2) == 0) ? 32'd1 : $urandom;
      model(hk, wd, p, to, code, cnt);
      run_test(hk, wd, 1'($urandom), 1'b1, p, to, code, cnt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
